// File: rtl/vga_compositor.sv
// vga_compositor: parametrised VGA raster engine compositing N_LAYERS priority rectangles over a
// background colour. Frame-synchronous dimming is built only when VGA_COMPOSITOR_DIM_EN is defined.
module vga_compositor #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned N_LAYERS = 8,
  parameter int unsigned COORD_W  = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_LAYERS*COORD_W-1:0]  rect_x,
  input  logic [N_LAYERS*COORD_W-1:0]  rect_y,
  input  logic [N_LAYERS*COORD_W-1:0]  rect_w,
  input  logic [N_LAYERS*COORD_W-1:0]  rect_h,
  input  logic [N_LAYERS*12-1:0]       rect_color,
  input  logic [N_LAYERS-1:0]          layer_en,
  input  logic [11:0]                  bg_color,
  input  logic                         dim_step,
  output logic                         hsync,
  output logic                         vsync,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b,
  output logic                         frame_start,
  output logic                         pix_active
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW1   = COORD_W + 1;

  // ---------------------------------------------------------------- pixel tick
  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DW'(DIV - 1));

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // ---------------------------------------------------------------- raster counters
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  // NOTE: next-state signals get their hold value first so no path leaves them unassigned
  // (which would infer a latch).
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (hcount_q == HW'(H_TOT - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VW'(V_TOT - 1)) ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // ---------------------------------------------------------------- stage 1: hit test
  logic [CW1-1:0]      x_ext, y_ext;
  logic [N_LAYERS-1:0] hit;
  logic                active_c, hsync_c, vsync_c, first_c;

  assign x_ext = CW1'(hcount_q);
  assign y_ext = CW1'(vcount_q);

  // Extents are computed one bit wider than the coordinates so x+w never wraps to a small value.
  for (genvar i = 0; i < N_LAYERS; i++) begin : g_hit
    logic [CW1-1:0] rx, ry, rx_end, ry_end;
    assign rx     = {1'b0, rect_x[i*COORD_W +: COORD_W]};
    assign ry     = {1'b0, rect_y[i*COORD_W +: COORD_W]};
    assign rx_end = rx + {1'b0, rect_w[i*COORD_W +: COORD_W]};
    assign ry_end = ry + {1'b0, rect_h[i*COORD_W +: COORD_W]};
    assign hit[i] = layer_en[i] && (x_ext >= rx) && (x_ext < rx_end)
                                && (y_ext >= ry) && (y_ext < ry_end);
  end

  assign active_c = (hcount_q < HW'(H_ACTIVE)) && (vcount_q < VW'(V_ACTIVE));
  assign hsync_c  = ((hcount_q >= HW'(H_ACTIVE + H_FP)) &&
                     (hcount_q <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign vsync_c  = ((vcount_q >= VW'(V_ACTIVE + V_FP)) &&
                     (vcount_q <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign first_c  = (hcount_q == '0) && (vcount_q == '0);

  logic [N_LAYERS-1:0]    s1_hit_q;
  logic [N_LAYERS*12-1:0] s1_color_q;
  logic [11:0]            s1_bg_q;
  logic                   s1_active_q, s1_hsync_q, s1_vsync_q, s1_first_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hit_q    <= '0;
      s1_color_q  <= '0;
      s1_bg_q     <= '0;
      s1_active_q <= 1'b0;
      s1_hsync_q  <= ~SYNC_POL;
      s1_vsync_q  <= ~SYNC_POL;
      s1_first_q  <= 1'b0;
    end else if (tick) begin
      s1_hit_q    <= hit;
      s1_color_q  <= rect_color;
      s1_bg_q     <= bg_color;
      s1_active_q <= active_c;
      s1_hsync_q  <= hsync_c;
      s1_vsync_q  <= vsync_c;
      s1_first_q  <= first_c;
    end
  end

  // ---------------------------------------------------------------- stage 2: priority select
  logic [11:0] sel_color;

  // Walk from the lowest priority upward so the lowest-index hit overwrites last.
  always_comb begin
    sel_color = s1_bg_q;
    for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) sel_color = s1_color_q[i*12 +: 12];
    end
    if (!s1_active_q) sel_color = '0;
  end

  logic [11:0] out_color;

`ifdef VGA_COMPOSITOR_DIM_EN
  logic       dim_step_q;
  logic [1:0] pend_q, dim_level_q, dim_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dim_step_q  <= 1'b0;
      pend_q      <= 2'd0;
      dim_level_q <= 2'd0;
    end else begin
      dim_step_q <= dim_step;
      if (dim_step && !dim_step_q) pend_q <= pend_q + 2'd1;
      if (tick && s1_first_q) dim_level_q <= pend_q;
    end
  end

  // Pixel (0,0) is registered on the same edge that loads the new level, so it uses pending directly.
  assign dim_eff   = s1_first_q ? pend_q : dim_level_q;
  assign out_color = {sel_color[11:8] >> dim_eff,
                      sel_color[7:4]  >> dim_eff,
                      sel_color[3:0]  >> dim_eff};
`else
  logic unused_dim;
  assign unused_dim = dim_step;
  assign out_color  = sel_color;
`endif

  // ---------------------------------------------------------------- output registers
  logic       hsync_q, vsync_q, frame_start_q, pix_active_q;
  logic [11:0] rgb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_q         <= '0;
      pix_active_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick && s1_first_q;
      if (tick) begin
        hsync_q      <= s1_hsync_q;
        vsync_q      <= s1_vsync_q;
        rgb_q        <= out_color;
        pix_active_q <= s1_active_q;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = frame_start_q;
  assign pix_active  = pix_active_q;

endmodule

// File: tb/tb_vga_compositor.sv
// Directed self-checking bench for vga_compositor using a reduced raster so several frames fit.
// Expected pixel timing: output of linear pixel p appears after clk edge 2*(p+2) counted from release.
module tb_vga_compositor;

  localparam int DIV = 2;
  localparam int HA = 112, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 64,  VFP = 2, VS = 2, VBP = 3;
  localparam int NL = 4, CW = 11;
  localparam int HT = HA + HFP + HS + HBP;   // 128
  localparam int VT = VA + VFP + VS + VBP;   // 71
  localparam int FRAME = HT * VT;
`ifdef VGA_COMPOSITOR_DIM_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NL*CW-1:0]   rect_x, rect_y, rect_w, rect_h;
  logic [NL*12-1:0]   rect_color;
  logic [NL-1:0]      layer_en;
  logic [11:0]        bg_color;
  logic               dim_step;
  logic               hsync, vsync, frame_start, pix_active;
  logic [3:0]         vga_r, vga_g, vga_b;
  logic [11:0]        rgb;

  int n_checks = 0;
  int n_fails  = 0;
  int edge_cnt;

  assign rgb = {vga_r, vga_g, vga_b};

  vga_compositor #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .N_LAYERS(NL), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_color(rect_color), .layer_en(layer_en), .bg_color(bg_color),
    .dim_step(dim_step),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .pix_active(pix_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits until the outputs show pixel (h,v) of frame f (frames counted from reset release).
  task automatic at_pixel(input int h, input int v, input int f);
    int target;
    target = 2 * (f * FRAME + v * HT + h + 2);
    if (edge_cnt > target) begin
      n_checks++;
      n_fails++;
      $error("FAIL schedule: edge %0d already past target %0d", edge_cnt, target);
    end
    while (edge_cnt < target) @(negedge clk);
  endtask

  task automatic set_layer(input int i, input int x, input int y, input int w, input int h,
                           input logic [11:0] c);
    rect_x[i*CW +: CW]     = CW'(x);
    rect_y[i*CW +: CW]     = CW'(y);
    rect_w[i*CW +: CW]     = CW'(w);
    rect_h[i*CW +: CW]     = CW'(h);
    rect_color[i*12 +: 12] = c;
  endtask

  initial begin
    dim_step   = 1'b0;
    rect_x     = '0;
    rect_y     = '0;
    rect_w     = '0;
    rect_h     = '0;
    rect_color = '0;
    set_layer(0, 20, 20, 8, 12, 12'h0F0);
    set_layer(1, 100, 50, 10, 10, 12'hF00);
    set_layer(2, 2040, 0, 20, 70, 12'h0FF);
    set_layer(3, 16, 16, 16, 16, 12'hFFF);
    layer_en = 4'hF;
    bg_color = 12'h00F;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hsync", 12'(hsync), 12'h1);
    check("rst_vsync", 12'(vsync), 12'h1);
    check("rst_rgb", rgb, 12'h000);
    check("rst_frame_start", 12'(frame_start), 12'h0);
    check("rst_pix_active", 12'(pix_active), 12'h0);
    rst = 1'b1;

    // Frame 0, line 0: alignment, blanking, hsync window
    at_pixel(0, 0, 0);
    check("f0_frame_start", 12'(frame_start), 12'h1);
    check("f0_00_rgb", rgb, 12'h00F);
    check("f0_00_active", 12'(pix_active), 12'h1);
    check("f0_00_hsync", 12'(hsync), 12'h1);
    check("f0_00_vsync", 12'(vsync), 12'h1);
    @(negedge clk);
    check("fs_one_clk", 12'(frame_start), 12'h0);
    check("rgb_hold_between_ticks", rgb, 12'h00F);
    at_pixel(111, 0, 0);
    check("last_active", 12'(pix_active), 12'h1);
    at_pixel(112, 0, 0);
    check("first_blank_active", 12'(pix_active), 12'h0);
    check("first_blank_rgb", rgb, 12'h000);
    at_pixel(115, 0, 0);
    check("hsync_before", 12'(hsync), 12'h1);
    at_pixel(116, 0, 0);
    check("hsync_start", 12'(hsync), 12'h0);
    at_pixel(123, 0, 0);
    check("hsync_last", 12'(hsync), 12'h0);
    at_pixel(124, 0, 0);
    check("hsync_end", 12'(hsync), 12'h1);

    // Far-right rectangle must not wrap onto x=0..8
    at_pixel(0, 10, 0);
    check("nowrap_x0", rgb, 12'h00F);
    at_pixel(8, 10, 0);
    check("nowrap_x8", rgb, 12'h00F);

    // Overlap priority and layer disable
    at_pixel(16, 16, 0);
    check("l3_only", rgb, 12'hFFF);
    at_pixel(20, 20, 0);
    check("overlap_l0_wins", rgb, 12'h0F0);
    at_pixel(27, 29, 0);
    check("overlap_corner", rgb, 12'h0F0);
    at_pixel(28, 29, 0);
    check("l3_right_of_l0", rgb, 12'hFFF);
    at_pixel(22, 30, 0);
    layer_en[0] = 1'b0;
    at_pixel(23, 30, 0);
    check("sampled_before_disable", rgb, 12'h0F0);
    at_pixel(24, 30, 0);
    check("after_disable_white", rgb, 12'hFFF);
    set_layer(2, 40, 40, 0, 10, 12'h0FF);

    // Zero-width layer, dim request mid-frame
    at_pixel(40, 40, 0);
    check("w0_never_drawn", rgb, 12'h00F);
    at_pixel(50, 45, 0);
    dim_step = 1'b1;
    at_pixel(60, 45, 0);
    dim_step = 1'b0;
    at_pixel(99, 50, 0);
    check("red_left_edge_bg", rgb, 12'h00F);
    at_pixel(100, 50, 0);
    check("red_origin_undimmed", rgb, 12'hF00);
    at_pixel(109, 59, 0);
    check("red_far_corner", rgb, 12'hF00);
    at_pixel(110, 59, 0);
    check("red_past_corner_bg", rgb, 12'h00F);

    // Vertical blanking and vsync window
    at_pixel(0, 64, 0);
    check("vblank_active", 12'(pix_active), 12'h0);
    check("vblank_rgb", rgb, 12'h000);
    at_pixel(0, 65, 0);
    check("vsync_before", 12'(vsync), 12'h1);
    at_pixel(0, 66, 0);
    check("vsync_start", 12'(vsync), 12'h0);
    at_pixel(127, 67, 0);
    check("vsync_last", 12'(vsync), 12'h0);
    at_pixel(0, 68, 0);
    check("vsync_end", 12'(vsync), 12'h1);

    // Frame 1: new dim level applies from pixel (0,0)
    at_pixel(0, 0, 1);
    check("f1_frame_start", 12'(frame_start), 12'h1);
    check("f1_bg_dim", rgb, DIM ? 12'h007 : 12'h00F);
    at_pixel(100, 50, 1);
    check("f1_red_dim", rgb, DIM ? 12'h700 : 12'hF00);
    for (int k = 0; k < 3; k++) begin
      dim_step = 1'b1;
      repeat (2) @(negedge clk);
      dim_step = 1'b0;
      repeat (2) @(negedge clk);
    end
    at_pixel(100, 55, 1);
    check("f1_level_held", rgb, DIM ? 12'h700 : 12'hF00);

    // Frame 2: four edges total wrap the level back to 0
    at_pixel(0, 0, 2);
    check("f2_bg_level0", rgb, 12'h00F);
    at_pixel(100, 50, 2);
    check("f2_red_level0", rgb, 12'hF00);

    // Mid-line reset while red is on the outputs
    at_pixel(105, 52, 2);
    rst = 1'b0;
    #1;
    check("midrst_rgb", rgb, 12'h000);
    check("midrst_hsync", 12'(hsync), 12'h1);
    check("midrst_vsync", 12'(vsync), 12'h1);
    check("midrst_active", 12'(pix_active), 12'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    at_pixel(0, 0, 0);
    check("restart_frame_start", 12'(frame_start), 12'h1);
    check("restart_rgb", rgb, 12'h00F);
    at_pixel(100, 50, 0);
    check("restart_red", rgb, 12'hF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
